// File: rtl/game_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_logic                                                   |
// | Description : Frame-stepped Breakout game-state engine. Each accepted      |
// |               FRAME_DONE pulse advances paddle, ball, blocks and lives by  |
// |               exactly one frame through a 4-stage sequencer.               |
// | Ports       : CLK, RESET (sync, active-high), FRAME_DONE (1-cycle pulse),  |
// |               BTN_LEFT/BTN_RIGHT/BTN_LAUNCH (levels, sampled at frame),    |
// |               PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,     |
// |               LIVES, SCORE, GAME_OVER, WON (all registered, commit-aligned)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module game_logic #(
   parameter int PADDLE_SPEED = 4,
   parameter int BALL_SPEED   = 2,
   parameter int START_LIVES  = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FRAME_DONE,
   input  logic        BTN_LEFT,
   input  logic        BTN_RIGHT,
   input  logic        BTN_LAUNCH,
   output logic [9:0]  PADDLE_X_PIXEL,
   output logic [9:0]  BALL_X_PIXEL,
   output logic [9:0]  BALL_Y_PIXEL,
   output logic [71:0] BLOCK_STATE,
   output logic [1:0]  LIVES,
   output logic [6:0]  SCORE,
   output logic        GAME_OVER,
   output logic        WON
);

   // Geometry, all 11 bits so that a step past zero stays visible.
   localparam logic [10:0] c_X_MIN     = 11'd88;
   localparam logic [10:0] c_X_END     = 11'd712;
   localparam logic [10:0] c_Y_MIN     = 11'd40;
   localparam logic [10:0] c_PAD_Y     = 11'd560;
   localparam logic [10:0] c_PAD_LEN   = 11'd64;
   localparam logic [10:0] c_PAD_HALF  = 11'd32;
   localparam logic [10:0] c_PAD_MAX   = 11'd648;
   localparam logic [10:0] c_PAD_RST   = 11'd368;
   localparam logic [10:0] c_BALL      = 11'd8;
   localparam logic [10:0] c_BALL_HALF = 11'd4;
   localparam logic [10:0] c_BALL_OFS  = 11'd28;
   localparam logic [10:0] c_REST_Y    = 11'd552;
   localparam logic [10:0] c_MISS_Y    = 11'd600;
   localparam logic [10:0] c_GRID_X0   = 11'd112;
   localparam logic [10:0] c_GRID_X1   = 11'd688;
   localparam logic [10:0] c_GRID_Y0   = 11'd80;
   localparam logic [10:0] c_GRID_Y1   = 11'd144;
   localparam logic [10:0] c_PSPD      = 11'(PADDLE_SPEED);
   localparam logic [10:0] c_BSPD      = 11'(BALL_SPEED);
   localparam logic [1:0]  c_LIVES0    = 2'(START_LIVES);
   localparam logic [6:0]  c_SCORE_MAX = 7'd72;

   typedef enum logic [2:0] {
      SEQ_IDLE, SEQ_PADDLE, SEQ_BALL, SEQ_COLLIDE, SEQ_COMMIT
   } seq_t;

   typedef enum logic [1:0] {
      GS_SERVE, GS_PLAY, GS_OVER, GS_WON
   } game_t;

   seq_t        seq_q;
   game_t       game_q, res_game_q, game_d;
   logic [9:0]  paddle_q, ball_x_q, ball_y_q;
   logic        dx_q, dy_q;                 // dx 1 = right, dy 1 = down
   logic [71:0] blocks_q;
   logic [1:0]  lives_q;
   logic [6:0]  score_q;
   logic        over_q, won_q;
   logic        btn_l_q, btn_r_q, btn_go_q;
   logic [10:0] pad_n_q, nx_q, ny_q;
   logic [9:0]  res_pad_q, res_x_q, res_y_q;
   logic        res_dx_q, res_dy_q;
   logic [71:0] res_blocks_q;
   logic [1:0]  res_lives_q;
   logic [6:0]  res_score_q;

   logic [10:0] pad_d, nx_d, ny_d, pad_c_d, x_d, y_d;
   logic        dx_d, dy_d;
   logic [71:0] blocks_d;
   logic [1:0]  lives_d;
   logic [6:0]  score_d;

   logic [10:0] w_pad, w_cx, w_cy;
   logic [3:0]  w_col;
   logic [2:0]  w_row;
   logic [6:0]  w_idx;
   logic        w_in_grid, w_pad_hit;

   assign w_pad = {1'b0, paddle_q};

   // PADDLE stage: the paddle only moves while the game is live.
   always_comb begin
      pad_d = w_pad;
      if (game_q == GS_SERVE || game_q == GS_PLAY) begin
         if (btn_l_q && !btn_r_q)
            pad_d = (w_pad < c_X_MIN + c_PSPD) ? c_X_MIN : w_pad - c_PSPD;
         else if (btn_r_q && !btn_l_q)
            pad_d = (w_pad + c_PSPD > c_PAD_MAX) ? c_PAD_MAX : w_pad + c_PSPD;
      end
   end

   // BALL stage: raw next position before any collision resolution.
   assign nx_d = dx_q ? {1'b0, ball_x_q} + c_BSPD : {1'b0, ball_x_q} - c_BSPD;
   assign ny_d = dy_q ? {1'b0, ball_y_q} + c_BSPD : {1'b0, ball_y_q} - c_BSPD;

   // COLLIDE stage helpers; block lookup uses the unresolved centre point.
   assign w_cx      = nx_q + c_BALL_HALF;
   assign w_cy      = ny_q + c_BALL_HALF;
   assign w_in_grid = (w_cx >= c_GRID_X0) && (w_cx < c_GRID_X1) &&
                      (w_cy >= c_GRID_Y0) && (w_cy < c_GRID_Y1);
   assign w_col     = 4'((w_cx - c_GRID_X0) >> 6);
   assign w_row     = 3'((w_cy - c_GRID_Y0) >> 3);
   assign w_idx     = {4'd0, w_row} * 7'd9 + {3'd0, w_col};
   // Only a downward ball that was fully above the paddle row can land on it.
   assign w_pad_hit = dy_q && ({1'b0, ball_y_q} + c_BALL <= c_PAD_Y) &&
                      (ny_q + c_BALL > c_PAD_Y) && (nx_q + c_BALL > pad_n_q) &&
                      (nx_q < pad_n_q + c_PAD_LEN);

   always_comb begin
      game_d   = game_q;
      pad_c_d  = pad_n_q;
      x_d      = {1'b0, ball_x_q};
      y_d      = {1'b0, ball_y_q};
      dx_d     = dx_q;
      dy_d     = dy_q;
      blocks_d = blocks_q;
      lives_d  = lives_q;
      score_d  = score_q;
      case (game_q)
         GS_SERVE: begin
            x_d = pad_n_q + c_BALL_OFS;
            y_d = c_REST_Y;
            if (btn_go_q) begin
               game_d = GS_PLAY;
               dx_d   = 1'b1;
               dy_d   = 1'b0;
            end
         end
         GS_PLAY: begin
            x_d = nx_q;
            y_d = ny_q;
            if (nx_q < c_X_MIN) begin
               x_d  = c_X_MIN;
               dx_d = 1'b1;
            end else if (nx_q + c_BALL > c_X_END) begin
               x_d  = c_X_END - c_BALL;
               dx_d = 1'b0;
            end
            if (ny_q < c_Y_MIN) begin
               y_d  = c_Y_MIN;
               dy_d = 1'b1;
            end
            if (w_pad_hit) begin
               y_d  = c_REST_Y;
               dy_d = 1'b0;
               dx_d = !(nx_q + c_BALL_HALF < pad_n_q + c_PAD_HALF);
            end
            if (w_in_grid && blocks_q[w_idx]) begin
               blocks_d[w_idx] = 1'b0;
               dy_d            = !dy_d;
               if (score_q < c_SCORE_MAX)
                  score_d = score_q + 7'd1;
            end
            // Clearing the last block wins even if this frame also misses.
            if (blocks_d == '0) begin
               game_d = GS_WON;
            end else if (ny_q >= c_MISS_Y) begin
               if (lives_q > 2'd1) begin
                  lives_d = lives_q - 2'd1;
                  game_d  = GS_SERVE;
                  x_d     = pad_n_q + c_BALL_OFS;
                  y_d     = c_REST_Y;
               end else begin
                  lives_d = 2'd0;
                  game_d  = GS_OVER;
               end
            end
         end
         default: begin
            if (btn_go_q) begin
               game_d   = GS_SERVE;
               pad_c_d  = c_PAD_RST;
               x_d      = c_PAD_RST + c_BALL_OFS;
               y_d      = c_REST_Y;
               dx_d     = 1'b1;
               dy_d     = 1'b0;
               blocks_d = '1;
               lives_d  = c_LIVES0;
               score_d  = 7'd0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         seq_q        <= SEQ_IDLE;
         game_q       <= GS_SERVE;
         paddle_q     <= 10'(c_PAD_RST);
         ball_x_q     <= 10'(c_PAD_RST + c_BALL_OFS);
         ball_y_q     <= 10'(c_REST_Y);
         dx_q         <= 1'b1;
         dy_q         <= 1'b0;
         blocks_q     <= '1;
         lives_q      <= c_LIVES0;
         score_q      <= 7'd0;
         over_q       <= 1'b0;
         won_q        <= 1'b0;
         btn_l_q      <= 1'b0;
         btn_r_q      <= 1'b0;
         btn_go_q     <= 1'b0;
         pad_n_q      <= c_PAD_RST;
         nx_q         <= 11'd0;
         ny_q         <= 11'd0;
         res_game_q   <= GS_SERVE;
         res_pad_q    <= 10'(c_PAD_RST);
         res_x_q      <= 10'(c_PAD_RST + c_BALL_OFS);
         res_y_q      <= 10'(c_REST_Y);
         res_dx_q     <= 1'b1;
         res_dy_q     <= 1'b0;
         res_blocks_q <= '1;
         res_lives_q  <= c_LIVES0;
         res_score_q  <= 7'd0;
      end else begin
         case (seq_q)
            SEQ_IDLE: begin
               if (FRAME_DONE) begin
                  btn_l_q  <= BTN_LEFT;
                  btn_r_q  <= BTN_RIGHT;
                  btn_go_q <= BTN_LAUNCH;
                  seq_q    <= SEQ_PADDLE;
               end
            end
            SEQ_PADDLE: begin
               pad_n_q <= pad_d;
               seq_q   <= SEQ_BALL;
            end
            SEQ_BALL: begin
               nx_q  <= nx_d;
               ny_q  <= ny_d;
               seq_q <= SEQ_COLLIDE;
            end
            SEQ_COLLIDE: begin
               res_game_q   <= game_d;
               res_pad_q    <= 10'(pad_c_d);
               res_x_q      <= 10'(x_d);
               res_y_q      <= 10'(y_d);
               res_dx_q     <= dx_d;
               res_dy_q     <= dy_d;
               res_blocks_q <= blocks_d;
               res_lives_q  <= lives_d;
               res_score_q  <= score_d;
               seq_q        <= SEQ_COMMIT;
            end
            SEQ_COMMIT: begin
               // Every visible output updates on this single edge.
               game_q   <= res_game_q;
               paddle_q <= res_pad_q;
               ball_x_q <= res_x_q;
               ball_y_q <= res_y_q;
               dx_q     <= res_dx_q;
               dy_q     <= res_dy_q;
               blocks_q <= res_blocks_q;
               lives_q  <= res_lives_q;
               score_q  <= res_score_q;
               over_q   <= (res_game_q == GS_OVER);
               won_q    <= (res_game_q == GS_WON);
               seq_q    <= SEQ_IDLE;
            end
            default: seq_q <= SEQ_IDLE;
         endcase
      end
   end

   assign PADDLE_X_PIXEL = paddle_q;
   assign BALL_X_PIXEL   = ball_x_q;
   assign BALL_Y_PIXEL   = ball_y_q;
   assign BLOCK_STATE    = blocks_q;
   assign LIVES          = lives_q;
   assign SCORE          = score_q;
   assign GAME_OVER      = over_q;
   assign WON            = won_q;

endmodule
`default_nettype wire

// File: tb/tb_game_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_game_logic                                                |
// | Description : Directed bench for game_logic. A reference game model        |
// |               pushes the expected post-frame outputs into a queue at each  |
// |               frame pulse; they are popped and compared at the commit edge.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_game_logic;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FRAME_DONE = 1'b0;
   logic        BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0, BTN_LAUNCH = 1'b0;
   logic [9:0]  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
   logic [71:0] BLOCK_STATE;
   logic [1:0]  LIVES;
   logic [6:0]  SCORE;
   logic        GAME_OVER, WON;

   game_logic #(.PADDLE_SPEED(4), .BALL_SPEED(2), .START_LIVES(3)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .FRAME_DONE     (FRAME_DONE),
      .BTN_LEFT       (BTN_LEFT),
      .BTN_RIGHT      (BTN_RIGHT),
      .BTN_LAUNCH     (BTN_LAUNCH),
      .PADDLE_X_PIXEL (PADDLE_X_PIXEL),
      .BALL_X_PIXEL   (BALL_X_PIXEL),
      .BALL_Y_PIXEL   (BALL_Y_PIXEL),
      .BLOCK_STATE    (BLOCK_STATE),
      .LIVES          (LIVES),
      .SCORE          (SCORE),
      .GAME_OVER      (GAME_OVER),
      .WON            (WON)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          px, bx, by, lives, score, over, won;
      logic [71:0] blk;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference game state: st 0 serve, 1 play, 2 over, 3 won; dx/dy are +-1.
   int          m_px, m_bx, m_by, m_dx, m_dy, m_lives, m_score, m_st;
   logic [71:0] m_blk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.px = m_px; e.bx = m_bx; e.by = m_by; e.lives = m_lives; e.score = m_score;
      e.over = (m_st == 2) ? 1 : 0; e.won = (m_st == 3) ? 1 : 0; e.blk = m_blk;
      return e;
   endfunction

   task automatic model_reset();
      m_px = 368; m_bx = 396; m_by = 552; m_dx = 1; m_dy = -1;
      m_blk = '1; m_lives = 3; m_score = 0; m_st = 0;
   endtask

   task automatic model_step(input bit l, input bit r, input bit go);
      int nx, ny, x, y, dx, dy, cx, cy, idx;
      if (m_st >= 2) begin
         if (go) model_reset();
         return;
      end
      if (l && !r) m_px = (m_px - 4 < 88) ? 88 : m_px - 4;
      else if (r && !l) m_px = (m_px + 4 > 648) ? 648 : m_px + 4;
      if (m_st == 0) begin
         m_bx = m_px + 28; m_by = 552;
         if (go) begin m_st = 1; m_dx = 1; m_dy = -1; end
         return;
      end
      nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy;
      x = nx; y = ny; dx = m_dx; dy = m_dy;
      if (nx < 88) begin x = 88; dx = 1; end
      else if (nx + 8 > 712) begin x = 704; dx = -1; end
      if (ny < 40) begin y = 40; dy = 1; end
      if (m_dy == 1 && m_by + 8 <= 560 && ny + 8 > 560 && nx + 8 > m_px && nx < m_px + 64) begin
         y = 552; dy = -1; dx = (nx + 4 < m_px + 32) ? -1 : 1;
      end
      cx = nx + 4; cy = ny + 4;
      if (cx >= 112 && cx < 688 && cy >= 80 && cy < 144) begin
         idx = ((cy - 80) / 8) * 9 + (cx - 112) / 64;
         if (m_blk[idx]) begin
            m_blk[idx] = 1'b0; dy = -dy;
            if (m_score < 72) m_score++;
         end
      end
      m_bx = x; m_by = y; m_dx = dx; m_dy = dy;
      if (m_blk == '0) m_st = 3;
      else if (ny >= 600) begin
         if (m_lives > 1) begin m_lives--; m_st = 0; m_bx = m_px + 28; m_by = 552; end
         else begin m_lives = 0; m_st = 2; end
      end
   endtask

   task automatic cmp(input exp_t e);
      chk("paddle_x", PADDLE_X_PIXEL, e.px);
      chk("ball_x", BALL_X_PIXEL, e.bx);
      chk("ball_y", BALL_Y_PIXEL, e.by);
      chk("blocks", BLOCK_STATE, e.blk);
      chk("lives", LIVES, e.lives);
      chk("score", SCORE, e.score);
      chk("game_over", GAME_OVER, e.over);
      chk("won", WON, e.won);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1; FRAME_DONE = 1'b0;
      BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_LAUNCH = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      sbq.delete();
   endtask

   task automatic chk_reset_vals();
      chk("rst_paddle", PADDLE_X_PIXEL, 368);
      chk("rst_ball_x", BALL_X_PIXEL, 396);
      chk("rst_ball_y", BALL_Y_PIXEL, 552);
      chk("rst_blocks", BLOCK_STATE, {72{1'b1}});
      chk("rst_lives", LIVES, 3);
      chk("rst_score", SCORE, 0);
      chk("rst_over", GAME_OVER, 0);
      chk("rst_won", WON, 0);
   endtask

   // One game frame: pulse, model, stability before commit, compare after.
   task automatic frame(input bit l, input bit r, input bit go);
      exp_t prev, e;
      prev = snap();
      @(negedge CLK);
      BTN_LEFT = l; BTN_RIGHT = r; BTN_LAUNCH = go; FRAME_DONE = 1'b1;
      model_step(l, r, go);
      sbq.push_back(snap());
      @(negedge CLK);
      FRAME_DONE = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("hold_paddle", PADDLE_X_PIXEL, prev.px);
      chk("hold_ball_y", BALL_Y_PIXEL, prev.by);
      @(posedge CLK);
      #1;
      chk("sb_depth", sbq.size(), 1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         cmp(e);
      end
   endtask

   initial begin
      bit found;
      int lv;

      // Reset
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      #1;
      chk_reset_vals();

      // Serve-state paddle movement and clamp
      for (int i = 0; i < 10; i++) frame(0, 1, 0);
      chk("serve_paddle_10", PADDLE_X_PIXEL, 408);
      chk("serve_ball_x_10", BALL_X_PIXEL, 436);
      for (int i = 0; i < 100; i++) frame(0, 1, 0);
      chk("paddle_clamp_right", PADDLE_X_PIXEL, 648);
      frame(1, 1, 0);
      chk("both_buttons", PADDLE_X_PIXEL, 648);

      // Launch and right-wall bounce
      frame(0, 0, 1);
      chk("launch_x", BALL_X_PIXEL, 676);
      chk("launch_y", BALL_Y_PIXEL, 552);
      frame(0, 0, 0);
      chk("first_move_x", BALL_X_PIXEL, 678);
      chk("first_move_y", BALL_Y_PIXEL, 550);
      for (int i = 0; i < 13; i++) frame(0, 0, 0);
      chk("wall_frame15_x", BALL_X_PIXEL, 704);
      repeat (2) frame(0, 0, 0);
      chk("wall_after_x", BALL_X_PIXEL, 702);

      // First block hit from the centre serve
      do_reset();
      frame(0, 0, 1);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         frame(0, 0, 0);
         if (SCORE != 7'd0) found = 1'b1;
      end
      chk("hit_seen", found, 1);
      chk("hit_score", SCORE, 1);
      chk("hit_cleared_count", $countones(~BLOCK_STATE), 1);
      chk("hit_bit70", BLOCK_STATE[70], 0);
      chk("hit_ball_y", BALL_Y_PIXEL, 138);
      frame(0, 0, 0);
      chk("hit_dy_down", BALL_Y_PIXEL, 140);

      // Misses down to game over, then restart
      do_reset();
      frame(0, 0, 1);
      found = 1'b0;
      for (int i = 0; i < 1500 && !found; i++) begin
         frame(1, 0, 0);
         if (LIVES != 2'd3) found = 1'b1;
      end
      chk("miss1_seen", found, 1);
      chk("miss1_lives", LIVES, 2);
      chk("miss1_paddle", PADDLE_X_PIXEL, 88);
      chk("miss1_ball_x", BALL_X_PIXEL, 116);
      chk("miss1_ball_y", BALL_Y_PIXEL, 552);
      for (int k = 0; k < 2; k++) begin
         frame(1, 0, 1);
         lv = m_lives;
         found = 1'b0;
         for (int i = 0; i < 1500 && !found; i++) begin
            frame(1, 0, 0);
            if (m_lives != lv) found = 1'b1;
         end
         chk("miss_next_seen", found, 1);
      end
      chk("over_flag", GAME_OVER, 1);
      chk("over_lives", LIVES, 0);
      frame(1, 0, 0);
      chk("over_frozen_flag", GAME_OVER, 1);
      frame(0, 0, 1);
      chk_reset_vals();

      // Reset while a frame update is in flight
      do_reset();
      @(negedge CLK);
      BTN_RIGHT = 1'b1; FRAME_DONE = 1'b1;
      @(negedge CLK);
      FRAME_DONE = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      repeat (6) @(negedge CLK);
      chk("midreset_paddle", PADDLE_X_PIXEL, 368);
      chk("midreset_ball_x", BALL_X_PIXEL, 396);

      // Second pulse inside the sequence must be dropped
      @(negedge CLK);
      BTN_RIGHT = 1'b1; FRAME_DONE = 1'b1;
      @(negedge CLK);
      FRAME_DONE = 1'b0;
      @(negedge CLK);
      FRAME_DONE = 1'b1;
      @(negedge CLK);
      FRAME_DONE = 1'b0;
      repeat (8) @(negedge CLK);
      chk("ignored_pulse_paddle", PADDLE_X_PIXEL, 372);
      chk("ignored_pulse_ball_x", BALL_X_PIXEL, 400);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
